// File: rtl/rmw_long_latency_pkg.sv
// Shared types for the long-latency read-modify-write table.
// Holds ids, tags, words and the in-flight entry bundle.
package rmw_long_latency_pkg;

  localparam int LAT_DEF = 8;

  typedef logic [3:0] id_t;
  typedef logic [3:0] tag_t;
  typedef logic [7:0] word_t;

  typedef struct packed {
    logic  vld;
    id_t   id;
    tag_t  tag;
    word_t word;
  } ent_t;

  // Replace an entry's word when a write to its id lands.
  function automatic ent_t snoop(
    input ent_t  e,
    input logic  wr,
    input id_t   wr_id,
    input word_t wr_word
  );
    ent_t r;
    r = e;
    if (wr && e.id == wr_id) r.word = wr_word;
    return r;
  endfunction

endpackage

// File: rtl/rmw_long_latency_tbl_pipe.sv
// In-flight read pipeline: LAT-deep shift register.
// Every stage snoops the write port as it advances.
module rmw_long_latency_tbl_pipe
  import rmw_long_latency_pkg::*;
#(
  parameter int LAT = LAT_DEF
) (
  input  logic  clk,
  input  logic  rst,
  input  ent_t  head,
  input  logic  wr,
  input  id_t   wr_id,
  input  word_t wr_word,
  output ent_t  tail
);

  ent_t stg [LAT];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LAT; i++)
        stg[i] <= '0;
    end else begin
      stg[0] <= snoop(head, wr, wr_id, wr_word);
      for (int i = 1; i < LAT; i++)
        stg[i] <= snoop(stg[i-1], wr, wr_id, wr_word);
    end
  end

  assign tail = stg[LAT-1];

endmodule

// File: rtl/rmw_long_latency_table.sv
// Flop table with fixed-latency, in-order, write-coherent reads.
// Responses reflect every write up to the output-register load.
module rmw_long_latency_table
  import rmw_long_latency_pkg::*;
#(
  parameter int LAT   = LAT_DEF,
  parameter int WORDS = 2**$bits(id_t)
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  tbl_wr_r,
  input  id_t   tbl_wr_id_r,
  input  word_t tbl_wr_word_r,
  input  logic  tbl_rd_r,
  input  id_t   tbl_rd_id_r,
  input  tag_t  tbl_rd_itag_r,
  output logic  tbl_rd_word_vld_r,
  output word_t tbl_rd_word_r,
  output tag_t  tbl_rd_ctag_r
);

  word_t mem [WORDS];
  ent_t  head;
  ent_t  tail;
  ent_t  resp;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < WORDS; i++)
        mem[i] <= '0;
    end else if (tbl_wr_r) begin
      mem[tbl_wr_id_r] <= tbl_wr_word_r;
    end
  end

  // Stage-0 snoop makes a same-cycle write win over the table read.
  always_comb begin
    head      = '0;
    head.vld  = tbl_rd_r;
    head.id   = tbl_rd_id_r;
    head.tag  = tbl_rd_itag_r;
    head.word = mem[tbl_rd_id_r];
  end

  rmw_long_latency_tbl_pipe #(
    .LAT(LAT)
  ) u_pipe (
    .clk    (clk),
    .rst    (rst),
    .head   (head),
    .wr     (tbl_wr_r),
    .wr_id  (tbl_wr_id_r),
    .wr_word(tbl_wr_word_r),
    .tail   (tail)
  );

  always_comb resp = snoop(tail, tbl_wr_r, tbl_wr_id_r, tbl_wr_word_r);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tbl_rd_word_vld_r <= 1'b0;
      tbl_rd_word_r     <= '0;
      tbl_rd_ctag_r     <= '0;
    end else begin
      tbl_rd_word_vld_r <= tail.vld;
      if (tail.vld) begin
        tbl_rd_word_r <= resp.word;
        tbl_rd_ctag_r <= tail.tag;
      end
    end
  end

endmodule

// File: tb/tb_rmw_long_latency_table.sv
// Bench for rmw_long_latency_table at LAT=8 and LAT=1 side by side.
// A table-plus-due-time model predicts every output cycle.
module tb_rmw_long_latency_table;
  import rmw_long_latency_pkg::*;

  localparam int LA = 8;
  localparam int LB = 1;

  logic  clk = 1'b0;
  logic  rst;
  logic  wr;
  id_t   wr_id;
  word_t wr_word;
  logic  rd;
  id_t   rd_id;
  tag_t  rd_tag;

  logic  vld_a, vld_b;
  word_t word_a, word_b;
  tag_t  tag_a, tag_b;

  always #5 clk = ~clk;

  rmw_long_latency_table #(.LAT(LA)) dut_a (
    .clk(clk), .rst(rst),
    .tbl_wr_r(wr), .tbl_wr_id_r(wr_id), .tbl_wr_word_r(wr_word),
    .tbl_rd_r(rd), .tbl_rd_id_r(rd_id), .tbl_rd_itag_r(rd_tag),
    .tbl_rd_word_vld_r(vld_a), .tbl_rd_word_r(word_a),
    .tbl_rd_ctag_r(tag_a)
  );

  rmw_long_latency_table #(.LAT(LB)) dut_b (
    .clk(clk), .rst(rst),
    .tbl_wr_r(wr), .tbl_wr_id_r(wr_id), .tbl_wr_word_r(wr_word),
    .tbl_rd_r(rd), .tbl_rd_id_r(rd_id), .tbl_rd_itag_r(rd_tag),
    .tbl_rd_word_vld_r(vld_b), .tbl_rd_word_r(word_b),
    .tbl_rd_ctag_r(tag_b)
  );

  typedef struct {
    int   due;
    id_t  id;
    tag_t tag;
  } req_t;

  req_t  qa[$];
  req_t  qb[$];
  word_t mt [16];
  int    cyc = 0;
  int    vectors = 0;
  int    errs = 0;
  logic  ev [2];
  word_t ew [2];
  tag_t  et [2];

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h cyc=%0d",
             tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    req_t r;
    @(posedge clk);
    cyc++;
    if (!rst) begin
      for (int i = 0; i < 16; i++) mt[i] = '0;
      qa.delete();
      qb.delete();
      for (int k = 0; k < 2; k++) begin
        ev[k] = 1'b0; ew[k] = '0; et[k] = '0;
      end
    end else begin
      if (wr) mt[wr_id] = wr_word;
      if (rd) begin
        qa.push_back('{cyc + LA, rd_id, rd_tag});
        qb.push_back('{cyc + LB, rd_id, rd_tag});
      end
      ev[0] = 1'b0;
      ev[1] = 1'b0;
      if (qa.size() > 0 && qa[0].due == cyc) begin
        r = qa.pop_front();
        ev[0] = 1'b1; ew[0] = mt[r.id]; et[0] = r.tag;
      end
      if (qb.size() > 0 && qb[0].due == cyc) begin
        r = qb.pop_front();
        ev[1] = 1'b1; ew[1] = mt[r.id]; et[1] = r.tag;
      end
    end
    #1;
    chk("vld_lat8",  {7'd0, vld_a}, {7'd0, ev[0]});
    chk("word_lat8", word_a, ew[0]);
    chk("ctag_lat8", {4'd0, tag_a}, {4'd0, et[0]});
    chk("vld_lat1",  {7'd0, vld_b}, {7'd0, ev[1]});
    chk("word_lat1", word_b, ew[1]);
    chk("ctag_lat1", {4'd0, tag_b}, {4'd0, et[1]});
  endtask

  task automatic idle(input int n);
    wr = 1'b0;
    rd = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst = 1'b0;
    wr = 1'b0; wr_id = '0; wr_word = '0;
    rd = 1'b0; rd_id = '0; rd_tag = '0;
    idle(2);
    rst = 1'b1;
    idle(1);

    // write then read id 3
    wr = 1'b1; wr_id = 4'd3; wr_word = 8'hA5;
    step();
    wr = 1'b0;
    rd = 1'b1; rd_id = 4'd3; rd_tag = 4'd2;
    step();
    idle(10);

    // same-cycle read/write of id 5
    rd = 1'b1; rd_id = 4'd5; rd_tag = 4'd9;
    wr = 1'b1; wr_id = 4'd5; wr_word = 8'h11;
    step();
    idle(10);

    // write snoop into an in-flight read of id 7
    rd = 1'b1; rd_id = 4'd7; rd_tag = 4'd1;
    step();
    idle(2);
    wr = 1'b1; wr_id = 4'd7; wr_word = 8'h42;
    step();
    idle(10);

    // back-to-back reads of ids 0..7
    for (int i = 0; i < 8; i++) begin
      wr = 1'b1; wr_id = id_t'(i); wr_word = word_t'(i * 17 + 1);
      step();
    end
    wr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rd = 1'b1; rd_id = id_t'(i); rd_tag = tag_t'(i);
      step();
    end
    idle(10);

    // reset with reads in flight
    for (int i = 0; i < 2; i++) begin
      rd = 1'b1; rd_id = id_t'(i + 2); rd_tag = tag_t'(i);
      step();
    end
    rst = 1'b0;
    rd_id = 4'd4;
    step();
    rd_id = 4'd5;
    step();
    rst = 1'b1;
    rd = 1'b1; rd_id = 4'd3; rd_tag = 4'd5;
    step();
    idle(10);

    // LAT=1 write-first then back-to-back read
    rd = 1'b1; rd_id = 4'd1; rd_tag = 4'd3;
    wr = 1'b1; wr_id = 4'd1; wr_word = 8'h7F;
    step();
    wr = 1'b0;
    rd_tag = 4'd4;
    step();
    idle(10);

    // randomized traffic with colliding ids and rare resets
    for (int i = 0; i < 400; i++) begin
      rd      = 1'($urandom_range(0, 1));
      rd_id   = id_t'($urandom_range(0, 7));
      rd_tag  = tag_t'($urandom);
      wr      = 1'($urandom_range(0, 1));
      wr_id   = id_t'($urandom_range(0, 7));
      wr_word = word_t'($urandom);
      rst     = ($urandom_range(0, 99) != 0);
      step();
    end
    rst = 1'b1;
    idle(12);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
